// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory channel between the CPU
// instruction-fetch port and the load/store port. Loads and stores win
// over fetches. The last fetched word sits in a one-entry buffer, and a
// per-access timeout keeps the pipeline moving if memory never answers.
module mem_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_data_o,
    output logic              inst_valid_o,
    input  logic              data_re_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_done_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_done_i,
    output logic              err_o,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_t;

    // cnt holds the number of cycles already spent waiting; the abort
    // fires on the edge that would complete the TIMEOUT-th cycle.
    localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] RD_ERR   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(16'h0800);

    state_t            state, next_state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] ibuf_addr;
    logic [DATA_W-1:0] ibuf_data;
    logic              ibuf_vld;
    logic              data_req;
    logic              launch_data, launch_inst, finish, abort;

    assign data_req     = data_re_i | data_we_i;
    assign inst_valid_o = ibuf_vld && (ibuf_addr == inst_addr_i);
    assign inst_data_o  = ibuf_data;
    assign stall_o      = (data_req && !data_done_o) || !inst_valid_o;
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state and one-cycle control strobes. A data request is not
    // relaunched while its done pulse is out, which lets a pending fetch
    // miss launch in that same cycle.
    always_comb begin
        next_state  = state;
        launch_data = 1'b0;
        launch_inst = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && !data_done_o) begin
                    launch_data = 1'b1;
                    next_state  = DATA;
                end else if (!inst_valid_o) begin
                    launch_inst = 1'b1;
                    next_state  = INST;
                end
            end
            DATA, INST: begin
                if (mem_done_i) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Downstream channel, timeout counter, data result and instruction buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            data_done_o  <= 1'b0;
            data_rdata_o <= '0;
            err_o        <= 1'b0;
            cnt          <= '0;
            ibuf_addr    <= '0;
            ibuf_data    <= '0;
            ibuf_vld     <= 1'b0;
        end else begin
            data_done_o <= 1'b0;
            if (launch_data) begin
                mem_en_o    <= 1'b1;
                mem_we_o    <= data_we_i;
                mem_addr_o  <= data_addr_i;
                mem_wdata_o <= data_wdata_i;
                cnt         <= '0;
            end else if (launch_inst) begin
                mem_en_o   <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= inst_addr_i;
                cnt        <= '0;
            end else if (finish || abort) begin
                mem_en_o <= 1'b0;
                if (abort) err_o <= 1'b1;
                if (state == DATA) begin
                    data_done_o <= 1'b1;
                    if (abort)              data_rdata_o <= RD_ERR;
                    else if (!mem_we_o)     data_rdata_o <= mem_rdata_i;
                    // An aborted store may still have landed, so it
                    // invalidates a matching buffer entry as well.
                    if (mem_we_o && mem_addr_o == ibuf_addr) ibuf_vld <= 1'b0;
                end else begin
                    ibuf_addr <= mem_addr_o;
                    ibuf_data <= abort ? NOP_WORD : mem_rdata_i;
                    ibuf_vld  <= 1'b1;
                end
            end else if (state != IDLE) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory, pushes the
// words it returns (or the abort words) into exp_q, and pops them when the
// arbiter presents a data result or a buffered instruction.
module tb_mem_arbiter;

    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] inst_addr_i;
    logic [DATA_W-1:0] inst_data_o;
    logic              inst_valid_o;
    logic              data_re_i;
    logic              data_we_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic [DATA_W-1:0] data_rdata_o;
    logic              data_done_o;
    logic              stall_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_done_i;
    logic              err_o;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o), .inst_valid_o(inst_valid_o),
        .data_re_i(data_re_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_done_o(data_done_o),
        .stall_o(stall_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_done_i(mem_done_i),
        .err_o(err_o), .dbg_state(dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory driver: answer the outstanding access for one cycle.
    task automatic respond(input logic [DATA_W-1:0] rdata);
        mem_done_i  = 1'b1;
        mem_rdata_i = rdata;
        @(negedge clk);
        mem_done_i  = 1'b0;
        mem_rdata_i = $urandom_range(0, 16'hFFFF);
    endtask

    task automatic sb_pop(output logic [DATA_W-1:0] v);
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow observed=0 expected=1");
            v = 'x;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    initial begin
        logic [DATA_W-1:0] e;
        int n;
        int en_seen;

        rst = 1'b0; inst_addr_i = 18'h00010;
        data_re_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
        mem_rdata_i = '0; mem_done_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", data_rdata_o, 0);
        chk("rst_done", data_done_o, 0);
        chk("rst_inst_valid", inst_valid_o, 0);
        chk("rst_stall", stall_o, 1);

        // Fetch 0x00010, memory answers one cycle after mem_en.
        rst = 1'b1;
        @(negedge clk);
        chk("f1_en", mem_en_o, 1);
        chk("f1_we", mem_we_o, 0);
        chk("f1_addr", mem_addr_o, 18'h00010);
        chk("f1_stall", stall_o, 1);
        exp_q.push_back(16'h6801);
        respond(16'h6801);
        sb_pop(e);
        chk("f1_valid", inst_valid_o, 1);
        chk("f1_data", inst_data_o, e);
        chk("f1_en_low", mem_en_o, 0);
        chk("f1_stall_low", stall_o, 0);
        // Stray done in IDLE must be ignored; no relaunch on a hit.
        respond(16'hDEAD);
        en_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_en_o) en_seen++;
            @(negedge clk);
        end
        chk("f1_no_relaunch", en_seen, 0);
        chk("idle_done_ignored", inst_data_o, 16'h6801);
        chk("idle_done_no_pulse", data_done_o, 0);

        // Load 0x0BF00 together with a fetch miss at 0x00020: data first.
        inst_addr_i = 18'h00020;
        data_re_i = 1'b1; data_addr_i = 18'h0BF00;
        @(negedge clk);
        chk("ld_en", mem_en_o, 1);
        chk("ld_we", mem_we_o, 0);
        chk("ld_addr", mem_addr_o, 18'h0BF00);
        exp_q.push_back(16'hA5C3);
        respond(16'hA5C3);
        sb_pop(e);
        chk("ld_done", data_done_o, 1);
        chk("ld_rdata", data_rdata_o, e);
        chk("ld_en_gap", mem_en_o, 0);
        data_re_i = 1'b0;
        @(negedge clk);
        chk("ld_done_pulse", data_done_o, 0);
        chk("f2_en", mem_en_o, 1);
        chk("f2_addr", mem_addr_o, 18'h00020);
        chk("ld_rdata_hold", data_rdata_o, 16'hA5C3);
        exp_q.push_back(16'h1111);
        respond(16'h1111);
        sb_pop(e);
        chk("f2_valid", inst_valid_o, 1);
        chk("f2_data", inst_data_o, e);

        // Store 0x1234 to the buffered address: buffer invalidated, refetch.
        data_we_i = 1'b1; data_addr_i = 18'h00020; data_wdata_i = 16'h1234;
        @(negedge clk);
        chk("st_en", mem_en_o, 1);
        chk("st_we", mem_we_o, 1);
        chk("st_addr", mem_addr_o, 18'h00020);
        chk("st_wdata", mem_wdata_o, 16'h1234);
        respond(16'h0000);
        chk("st_done", data_done_o, 1);
        chk("st_ibuf_cleared", inst_valid_o, 0);
        chk("st_rdata_hold", data_rdata_o, 16'hA5C3);
        data_we_i = 1'b0;
        @(negedge clk);
        chk("f3_en", mem_en_o, 1);
        chk("f3_we", mem_we_o, 0);
        chk("f3_addr", mem_addr_o, 18'h00020);
        exp_q.push_back(16'h2222);
        respond(16'h2222);
        sb_pop(e);
        chk("f3_valid", inst_valid_o, 1);
        chk("f3_data", inst_data_o, e);
        chk("pre_tmo_err", err_o, 0);

        // Load that memory never answers.
        data_re_i = 1'b1; data_addr_i = 18'h00300;
        @(negedge clk);
        chk("ldt_en", mem_en_o, 1);
        exp_q.push_back(16'hFFFF);
        n = 0;
        while (data_done_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ldt_cycles", n, TIMEOUT);
        sb_pop(e);
        chk("ldt_done", data_done_o, 1);
        chk("ldt_rdata", data_rdata_o, e);
        chk("ldt_err", err_o, 1);
        chk("ldt_en_low", mem_en_o, 0);
        data_re_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("ldt_err_sticky", err_o, 1);

        // Fetch that memory never answers.
        inst_addr_i = 18'h00040;
        @(negedge clk);
        chk("ft_en", mem_en_o, 1);
        chk("ft_addr", mem_addr_o, 18'h00040);
        exp_q.push_back(16'h0800);
        n = 0;
        while (inst_valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ft_cycles", n, TIMEOUT);
        sb_pop(e);
        chk("ft_data", inst_data_o, e);
        chk("ft_err", err_o, 1);

        // Asynchronous reset while a load is outstanding.
        data_re_i = 1'b1; data_addr_i = 18'h00500;
        @(negedge clk);
        chk("ar_en_before", mem_en_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_en", mem_en_o, 0);
        chk("ar_done", data_done_o, 0);
        chk("ar_err", err_o, 0);
        chk("ar_rdata", data_rdata_o, 0);
        chk("ar_inst_valid", inst_valid_o, 0);
        chk("ar_inst_data", inst_data_o, 0);
        data_re_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_state_idle", dbg_state, 0);
        chk("ar_stall", stall_o, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
